// File: rtl/strip_id_sel_if.sv
// Bundle for the strip selector: request, candidate stream, completion and table write.
interface strip_id_sel_if #(
    parameter int HEIGHT_W = 5,
    parameter int DEPTH    = 10,
    parameter int NCAND    = 3,
    parameter int ID_W     = 4
) ();
    localparam int RANK_W = (NCAND > 1) ? $clog2(NCAND) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [HEIGHT_W-1:0]   req_height;
    logic                  cand_valid;
    logic                  cand_ready;
    logic [ID_W-1:0]       cand_id;
    logic [RANK_W-1:0]     cand_rank;
    logic                  cand_last;
    logic                  abort;
    logic                  done;
    logic                  done_empty;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [NCAND*ID_W-1:0] wr_data;

    modport master (
        output req_valid, req_height, cand_ready, abort, wr_en, wr_addr, wr_data,
        input  req_ready, cand_valid, cand_id, cand_rank, cand_last, done, done_empty
    );

    modport slave (
        input  req_valid, req_height, cand_ready, abort, wr_en, wr_addr, wr_data,
        output req_ready, cand_valid, cand_id, cand_rank, cand_last, done, done_empty
    );
endinterface

// File: rtl/strip_id_sel.sv
// Strip-candidate selector: maps a block height to a prioritised table row and
// streams the valid strip IDs of that row one at a time, ending with a done pulse.
module strip_id_sel #(
    parameter int                          HEIGHT_W   = 5,
    parameter int                          MIN_H      = 4,
    parameter int                          DEPTH      = 10,
    parameter int                          NCAND      = 3,
    parameter int                          ID_W       = 4,
    parameter logic [ID_W-1:0]             INVALID_ID = 4'hD,
    parameter logic [DEPTH*NCAND*ID_W-1:0] INIT_TABLE = {12'hCBA, 12'h8DD, 12'h68D, 12'h46D, 12'h24D,
                                                         12'h012, 12'h301, 12'h53D, 12'h75D, 12'h97D}
) (
    input  logic         clk,
    input  logic         rst_n,
    strip_id_sel_if.slave bus
);
    localparam int RW     = NCAND * ID_W;
    localparam int RANK_W = (NCAND > 1) ? $clog2(NCAND) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    typedef logic [ID_W-1:0] slot_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     tbl [DEPTH];
    slot_t             row_buf [NCAND];
    logic [RANK_W-1:0] idx_q, idx_d;
    logic              empty_q, empty_d;
    logic              load;

    logic [HEIGHT_W-1:0] height;
    logic [31:0]         h_ext;
    logic [AW-1:0]       row;
    slot_t               sel [NCAND];
    logic [NCAND-1:0]    sel_valid;
    logic                sel_any;
    logic [RANK_W-1:0]   sel_first;
    logic [NCAND-1:0]    buf_valid;
    logic                has_next;
    logic [RANK_W-1:0]   next_idx;

    assign height = bus.req_height;

    // Row lookup for the requested height; heights below MIN_H see an all-invalid row.
    always_comb begin
        h_ext     = 32'(height);
        row       = '0;
        sel_any   = 1'b0;
        sel_first = '0;
        if (h_ext >= 32'(MIN_H)) begin
            if (h_ext - 32'(MIN_H) >= 32'(DEPTH - 1))
                row = AW'(DEPTH - 1);
            else
                row = AW'(h_ext - 32'(MIN_H));
        end
        for (int unsigned s = 0; s < NCAND; s++) begin
            if (h_ext < 32'(MIN_H))
                sel[s] = INVALID_ID;
            else
                sel[s] = tbl[row][(NCAND - 1 - s) * ID_W +: ID_W];
            sel_valid[s] = (sel[s] != INVALID_ID);
        end
        // Descending scan so the lowest valid slot is the one left standing.
        for (int unsigned s = NCAND; s > 0; s--) begin
            if (sel_valid[s-1]) begin
                sel_any   = 1'b1;
                sel_first = RANK_W'(s - 1);
            end
        end
    end

    // Next valid slot above the current index within the snapshotted row.
    always_comb begin
        has_next = 1'b0;
        next_idx = '0;
        for (int unsigned s = 0; s < NCAND; s++)
            buf_valid[s] = (row_buf[s] != INVALID_ID);
        for (int unsigned s = NCAND; s > 0; s--) begin
            if (buf_valid[s-1] && (32'(s - 1) > 32'(idx_q))) begin
                has_next = 1'b1;
                next_idx = RANK_W'(s - 1);
            end
        end
    end

    // Next-state logic for the IDLE -> EMIT/DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        empty_d = empty_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    load = 1'b1;
                    if (sel_any) begin
                        state_d = EMIT;
                        idx_d   = sel_first;
                        empty_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        empty_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.abort) begin
                    state_d = DONE;
                end else if (bus.cand_ready) begin
                    if (has_next)
                        idx_d = next_idx;
                    else
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, iteration index, empty flag and row snapshot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            empty_q <= 1'b0;
            for (int unsigned s = 0; s < NCAND; s++)
                row_buf[s] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            empty_q <= empty_d;
            if (load) begin
                for (int unsigned s = 0; s < NCAND; s++)
                    row_buf[s] <= sel[s];
            end
        end
    end

    // Candidate table: reloaded on reset, row writes with out-of-range rows dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++)
                tbl[r] <= INIT_TABLE[r * RW +: RW];
        end else if (bus.wr_en && (32'(bus.wr_addr) < 32'(DEPTH))) begin
            tbl[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.cand_valid = (state_q == EMIT);
    assign bus.cand_id    = (state_q == EMIT) ? row_buf[idx_q] : '0;
    assign bus.cand_rank  = (state_q == EMIT) ? idx_q : '0;
    assign bus.cand_last  = (state_q == EMIT) && !has_next;
    assign bus.done       = (state_q == DONE);
    assign bus.done_empty = (state_q == DONE) && empty_q;
endmodule

// File: doc/strip_id_sel.md
Name: strip_id_sel

Overview:
Parametrised strip-candidate selector for the placement datapath. It maps a requested block height to a prioritised row of strip IDs held in a writable table. It then streams the valid candidates one at a time over a ready/valid handshake, skipping invalid slots, and finishes with a done pulse. Placement control uses it to try strips in priority order and can abort early once a strip fits.

Parameters:
HEIGHT_W, 5, width of req_height
MIN_H, 4, height mapped to table row 0
DEPTH, 10, table rows; heights >= MIN_H+DEPTH-1 clamp to row DEPTH-1
NCAND, 3, candidate slots per row, slot 0 highest priority
ID_W, 4, strip ID width
INVALID_ID, 4'hD, slot value meaning "no strip"
INIT_TABLE, {12'hCBA,12'h8DD,12'h68D,12'h46D,12'h24D,12'h012,12'h301,12'h53D,12'h75D,12'h97D}, reset contents; row i at bits [i*NCAND*ID_W +: NCAND*ID_W], slot 0 in the most significant ID_W bits of the row
RANK_W, clog2(NCAND), width of cand_rank

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  lookup request
req_ready  out  1  selector idle, request accepted when both high
req_height  in  HEIGHT_W  height to look up
cand_valid  out  1  cand_id/cand_rank/cand_last valid
cand_ready  in  1  consumer rejects current candidate, wants next
cand_id  out  ID_W  current strip ID
cand_rank  out  RANK_W  slot index of cand_id within row
cand_last  out  1  no further valid candidate after this one
abort  in  1  stop iteration (strip found)
done  out  1  one-cycle pulse, request finished
done_empty  out  1  with done: zero candidates were offered
wr_en  in  1  table write strobe
wr_addr  in  clog2(DEPTH)  row to write
wr_data  in  NCAND*ID_W  new row, same packing as INIT_TABLE

Behaviour:
- Reset (rst_n low at an edge): state IDLE; table reloaded from INIT_TABLE; cand_valid, cand_id, cand_rank, cand_last, done, done_empty all 0; req_ready 1 after reset.
- Row select: height < MIN_H selects an all-invalid row. Otherwise row = min(height-MIN_H, DEPTH-1).
- States: IDLE, EMIT, DONE. req_ready = (state==IDLE).
- IDLE: on req_valid&&req_ready at edge T, snapshot the selected row into a row buffer; table writes after T do not affect this request. If the row has at least one slot != INVALID_ID, go to EMIT with idx = lowest valid slot. Otherwise go to DONE with empty flag set.
- EMIT: cand_valid=1 from cycle T+1. cand_id = buf[idx], cand_rank = idx. cand_last=1 iff no valid slot above idx. Outputs hold stable while cand_ready=0.
  - abort=1: go to DONE. abort wins over a simultaneous cand_ready.
  - cand_valid&&cand_ready&&!cand_last: idx advances to the next valid slot; the new candidate is presented the next cycle.
  - cand_valid&&cand_ready&&cand_last: go to DONE.
- DONE: single cycle. done=1; done_empty=1 only if the row had no valid slot. cand_valid=0. Next state IDLE.
- Minimum spacing: a new request is accepted 2 cycles after the final cand handshake, or after abort.
- Table write: wr_en at edge writes row wr_addr, visible to requests accepted on later edges. Write and acceptance on the same edge: the request snapshot sees the old row. wr_addr >= DEPTH is ignored. Writes are legal in any state.
- All outputs are functions of registers only; there is no input-to-output combinational path.
- Reset in any state aborts the iteration silently: no done pulse, table restored.
- abort or cand_ready outside EMIT is ignored.

Test Plan:
1. Reset, request height 4, cand_ready held 1 -> cand 9 (rank 0, last 0), then 7 (rank 1, last 1); slot D skipped; then done=1, done_empty=0; req_ready back high the next cycle.
2. Height 7 -> 3/0, 0/1, 1/2 (id/rank), last on rank 2. Heights 13 and 16 -> C, B, A (clamp). Height 12 -> single cand 8, last=1.
3. Height 3 -> no cand_valid; done=1, done_empty=1 at T+1.
4. Height 5, cand_ready low 6 cycles -> cand_id=7 held stable. Then abort together with cand_ready -> done, done_empty=0, no cand 5 offered.
5. During height-4 iteration, write row 0 = 12'hDDD -> current request still yields 9, 7. Next height-4 request -> done_empty=1. Also write row 3 = 12'h1D2 on the same edge a height-7 request is accepted -> old 3, 0, 1 emitted.
6. Reset asserted mid-EMIT after row 0 was rewritten -> all outputs 0, no done. A following height-4 request yields 9, 7 (INIT_TABLE restored).
